gcm_key_feed_ctrl: RTL and testbench
====================================

// Module: gcm_key_feed_ctrl
// PURPOSE
// Synthesizable sequencer between a 128-bit input word stream and the gcm/aes_top pair.
// Per session: takes 1 or 2 key words, pulses aes_top key expansion, raises key_expanded,
// then forwards IV, AADLEN, AAD and data words to gcm through a DEPTH-entry FIFO.
// Holds key_expanded until gcm_done. Supports 128- and 256-bit keys, selected per session.
// PARAMETERS
// BLK_BITS  128  stream/GCM block width; only 128 is supported
// KEY_BITS  256  aes_alg_key width (AES_MAX_KEY_BITS)
// DEPTH     4    forwarding FIFO entries; power of 2, >=2
// PORTS
// clk                 in   1         clock, rising edge
// reset               in   1         synchronous, active-high
// key_mode            in   1         0=AES-128, 1=AES-256; sampled with first key word
// s_blk               in   BLK_BITS  input word
// s_valid             in   1         input word valid
// s_ready             out  1         input word accepted when s_valid&&s_ready
// aes_alg_key         out  KEY_BITS  expansion key to aes_top
// aes_alg_en_key      out  1         1-cycle expansion start pulse
// aes128_mode         out  1         to aes_top
// aes256_mode         out  1         to aes_top
// aes_alg_done        in   1         aes_top done (en_o)
// aes_op_in_progress  in   1         aes_top busy
// key_expanded        out  1         to gcm; key schedule valid
// gcm_in_blk          out  BLK_BITS  FIFO head
// gcm_valid           out  1         FIFO non-empty && state==STREAM
// gcm_ready           in   1         gcm accepts when gcm_valid&&gcm_ready
// gcm_done            in   1         gcm session complete
// busy                out  1         state!=IDLE
// BEHAVIOUR
// - Reset: state=IDLE, FIFO flushed, all outputs 0 (aes_alg_key=0, both mode bits 0).
//   Reset mid-session aborts immediately; no pulse, no stale FIFO word survives.
// - FSM: IDLE -> KEY0 (always) ; KEY0 -acc,mode0-> EXPAND ; KEY0 -acc,mode1-> KEY1 ;
//   KEY1 -acc-> EXPAND ; EXPAND -pulse issued-> WAIT_EXP ; WAIT_EXP -aes_alg_done-> STREAM ;
//   STREAM -gcm_done-> IDLE.
// - s_ready: 1 in KEY0/KEY1; in STREAM = FIFO not full; 0 in EXPAND/WAIT_EXP/IDLE.
// - Key packing: 128: aes_alg_key={w0,128'b0}; 256: aes_alg_key={w0,w1}.
//   Mode bits latched at KEY0 accept; aes128_mode=~key_mode, aes256_mode=key_mode; held to IDLE.
// - EXPAND: assert aes_alg_en_key for exactly 1 cycle, only when !aes_op_in_progress;
//   earliest pulse is cycle after last key word accepted. Stall otherwise.
// - key_expanded: set on cycle after aes_alg_done in WAIT_EXP; cleared the cycle after
//   gcm_done; aes_alg_done outside WAIT_EXP is ignored.
// - FIFO: push on s_valid&&s_ready in STREAM, pop on gcm_valid&&gcm_ready; simultaneous
//   push+pop when full is legal (count unchanged); ptrs wrap mod DEPTH; gcm_in_blk stable
//   while gcm_valid&&!gcm_ready.
// - gcm_done: FIFO flushed on same edge as IDLE entry; leftover words are discarded.
// - Throughput: 1 word/cycle sustained in STREAM with gcm_ready high; in->out latency 1 cycle.
// STRUCTURE
// - Package gcm_pkg: GCM_BLK_BITS=128, AES_MAX_KEY_BITS=256, typedef gcm_blk_t,
//   enum feed_state_t {IDLE,KEY0,KEY1,EXPAND,WAIT_EXP,STREAM}.
// - One sub-module: gcm_blk_fifo (BLK_BITS, DEPTH; push/pop/flush, full/empty, count).
// - FSM, key packing and pulse logic live in this module.
// TESTING
// - 128-bit: K=000102..0f then IV,AADLEN,1 data word; aes_alg_done 12 cyc after pulse
//   -> aes_alg_key={K,128'b0}, aes128_mode=1, one en_key pulse, 3 words to gcm in order.
// - 256-bit: key_mode=1, w0=A5..A5, w1=5A..5A -> aes_alg_key={w0,w1}, aes256_mode=1.
// - aes_op_in_progress=1 for 5 cyc at EXPAND -> pulse delayed exactly until it drops, once.
// - DEPTH=4, gcm_ready=0, push 6 words -> s_ready low after 4; release -> all 6 in order.
// - gcm_done with 2 words queued -> key_expanded 0 next cycle, FIFO empty, next key accepted.
// - reset asserted in WAIT_EXP -> all outputs 0 next cycle; later aes_alg_done ignored.

Source files
------------

// File: rtl/gcm_pkg.sv
// Shared widths, block type and sequencer state encoding for the GCM key/stream feeder.
package gcm_pkg;

    localparam int unsigned GCM_BLK_BITS     = 128;
    localparam int unsigned AES_MAX_KEY_BITS = 256;

    typedef logic [GCM_BLK_BITS-1:0] gcm_blk_t;

    typedef enum logic [2:0] {
        IDLE,
        KEY0,
        KEY1,
        EXPAND,
        WAIT_EXP,
        STREAM
    } feed_state_t;

endpackage

// File: rtl/gcm_blk_fifo.sv
// Small power-of-two FIFO of GCM blocks with synchronous flush.
module gcm_blk_fifo
    import gcm_pkg::*;
#(
    parameter int unsigned BLK_BITS = GCM_BLK_BITS,
    parameter int unsigned DEPTH    = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [BLK_BITS-1:0]        din,
    output logic [BLK_BITS-1:0]        dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [BLK_BITS-1:0] mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    cnt_q;
    logic                push_ok;
    logic                pop_ok;

    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign dout    = mem[rd_ptr];
    assign pop_ok  = pop && !empty;
    // A push into a full FIFO is accepted only when a pop frees the slot on the same edge.
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/gcm_key_feed_ctrl.sv
// Sequencer: loads a 128/256-bit key into aes_top, triggers expansion, then streams
// IV/AADLEN/AAD/data words to gcm through a small FIFO until gcm reports done.
module gcm_key_feed_ctrl
    import gcm_pkg::*;
#(
    parameter int unsigned BLK_BITS = GCM_BLK_BITS,
    parameter int unsigned KEY_BITS = AES_MAX_KEY_BITS,
    parameter int unsigned DEPTH    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                key_mode,
    input  logic [BLK_BITS-1:0] s_blk,
    input  logic                s_valid,
    output logic                s_ready,
    output logic [KEY_BITS-1:0] aes_alg_key,
    output logic                aes_alg_en_key,
    output logic                aes128_mode,
    output logic                aes256_mode,
    input  logic                aes_alg_done,
    input  logic                aes_op_in_progress,
    output logic                key_expanded,
    output logic [BLK_BITS-1:0] gcm_in_blk,
    output logic                gcm_valid,
    input  logic                gcm_ready,
    input  logic                gcm_done,
    output logic                busy
);

    feed_state_t state;
    feed_state_t state_nxt;

    logic [KEY_BITS-1:0]     key_q;
    logic                    mode128_q;
    logic                    mode256_q;
    logic                    key_acc;
    logic                    fifo_push;
    logic                    fifo_pop;
    logic                    fifo_flush;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [$clog2(DEPTH):0]  fifo_count;
    logic [BLK_BITS-1:0]     fifo_dout;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     state_nxt = KEY0;
            KEY0:     if (key_acc) state_nxt = key_mode ? KEY1 : EXPAND;
            KEY1:     if (key_acc) state_nxt = EXPAND;
            EXPAND:   if (!aes_op_in_progress) state_nxt = WAIT_EXP;
            WAIT_EXP: if (aes_alg_done) state_nxt = STREAM;
            STREAM:   if (gcm_done) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_ready        = 1'b0;
        aes_alg_en_key = 1'b0;
        key_expanded   = 1'b0;
        gcm_valid      = 1'b0;
        fifo_flush     = 1'b0;
        busy           = (state != IDLE);
        case (state)
            KEY0, KEY1: s_ready = 1'b1;
            // Pulse lasts one cycle because the state leaves EXPAND on the same edge.
            EXPAND:     aes_alg_en_key = !aes_op_in_progress;
            STREAM: begin
                s_ready      = !fifo_full;
                key_expanded = 1'b1;
                gcm_valid    = (fifo_count != '0);
                fifo_flush   = gcm_done;
            end
            default: ;
        endcase
    end

    assign key_acc   = s_valid && s_ready;
    assign fifo_push = key_acc && (state == STREAM);
    assign fifo_pop  = gcm_valid && gcm_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            key_q     <= '0;
            mode128_q <= 1'b0;
            mode256_q <= 1'b0;
        end else if (state == KEY0 && key_acc) begin
            key_q                            <= '0;
            key_q[KEY_BITS-1 -: BLK_BITS]    <= s_blk;
            mode128_q                        <= ~key_mode;
            mode256_q                        <= key_mode;
        end else if (state == KEY1 && key_acc) begin
            key_q[KEY_BITS-BLK_BITS-1 -: BLK_BITS] <= s_blk;
        end else if (fifo_flush) begin
            key_q     <= '0;
            mode128_q <= 1'b0;
            mode256_q <= 1'b0;
        end
    end

    assign aes_alg_key = key_q;
    assign aes128_mode = mode128_q;
    assign aes256_mode = mode256_q;
    // Head is masked when empty so a flushed or never-written slot is never visible.
    assign gcm_in_blk  = fifo_empty ? '0 : fifo_dout;

    gcm_blk_fifo #(
        .BLK_BITS (BLK_BITS),
        .DEPTH    (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (fifo_flush),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (s_blk),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_gcm_key_feed_ctrl.sv
// Scoreboard bench for gcm_key_feed_ctrl: key packing, pulse timing, FIFO order and flush.
module tb_gcm_key_feed_ctrl;

    logic         clk;
    logic         reset;
    logic         key_mode;
    logic [127:0] s_blk;
    logic         s_valid;
    logic         s_ready;
    logic [255:0] aes_alg_key;
    logic         aes_alg_en_key;
    logic         aes128_mode;
    logic         aes256_mode;
    logic         aes_alg_done;
    logic         aes_op_in_progress;
    logic         key_expanded;
    logic [127:0] gcm_in_blk;
    logic         gcm_valid;
    logic         gcm_ready;
    logic         gcm_done;
    logic         busy;

    int unsigned  n_checks;
    int unsigned  n_fail;
    int unsigned  pulses;
    logic [127:0] sb [$];
    logic [127:0] exp_w;
    logic [127:0] words [6];
    logic [127:0] k128;
    logic [127:0] k3;
    logic [255:0] exp_key;

    gcm_key_feed_ctrl #(
        .BLK_BITS (128),
        .KEY_BITS (256),
        .DEPTH    (4)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .key_mode           (key_mode),
        .s_blk              (s_blk),
        .s_valid            (s_valid),
        .s_ready            (s_ready),
        .aes_alg_key        (aes_alg_key),
        .aes_alg_en_key     (aes_alg_en_key),
        .aes128_mode        (aes128_mode),
        .aes256_mode        (aes256_mode),
        .aes_alg_done       (aes_alg_done),
        .aes_op_in_progress (aes_op_in_progress),
        .key_expanded       (key_expanded),
        .gcm_in_blk         (gcm_in_blk),
        .gcm_valid          (gcm_valid),
        .gcm_ready          (gcm_ready),
        .gcm_done           (gcm_done),
        .busy               (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Holds a word on the input until accepted; words headed for gcm go to the scoreboard.
    task automatic send_word(input logic [127:0] blk, input bit fwd);
        int unsigned n;
        n       = 0;
        s_blk   = blk;
        s_valid = 1'b1;
        @(negedge clk);
        while (!s_ready && n < 40) begin
            n++;
            @(negedge clk);
        end
        if (!s_ready) begin
            check("accept_timeout", 256'(s_ready), 256'd1);
        end else if (fwd) begin
            sb.push_back(blk);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_drain;
        int unsigned n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            n++;
            tick();
        end
        check("drain_timeout", 256'(sb.size()), 256'd0);
    endtask

    always @(negedge clk) begin
        if (aes_alg_en_key) pulses++;
        if (gcm_valid && gcm_ready) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 256'(sb.size()), 256'd1);
            end else begin
                exp_w = sb.pop_front();
                check("gcm_word", 256'(gcm_in_blk), 256'(exp_w));
            end
        end
    end

    initial begin
        n_checks           = 0;
        n_fail             = 0;
        pulses             = 0;
        reset              = 1'b1;
        key_mode           = 1'b0;
        s_blk              = '0;
        s_valid            = 1'b0;
        aes_alg_done       = 1'b0;
        aes_op_in_progress = 1'b0;
        gcm_ready          = 1'b1;
        gcm_done           = 1'b0;
        for (int i = 0; i < 6; i++) words[i] = {4{32'hC0DE_0000 + 32'(i)}};
        k128 = 128'h000102030405060708090a0b0c0d0e0f;
        k3   = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

        repeat (3) tick();
        check("rst_s_ready", 256'(s_ready), 256'd0);
        check("rst_key", aes_alg_key, 256'd0);
        check("rst_m128", 256'(aes128_mode), 256'd0);
        check("rst_m256", 256'(aes256_mode), 256'd0);
        check("rst_en_key", 256'(aes_alg_en_key), 256'd0);
        check("rst_key_exp", 256'(key_expanded), 256'd0);
        check("rst_gcm_valid", 256'(gcm_valid), 256'd0);
        check("rst_busy", 256'(busy), 256'd0);
        reset = 1'b0;

        // AES-128 session
        send_word(k128, 1'b0);
        exp_key = {k128, 128'd0};
        check("k128_en_key", 256'(aes_alg_en_key), 256'd1);
        check("k128_key", aes_alg_key, exp_key);
        check("k128_m128", 256'(aes128_mode), 256'd1);
        check("k128_m256", 256'(aes256_mode), 256'd0);
        check("k128_busy", 256'(busy), 256'd1);
        tick();
        check("k128_en_once", 256'(aes_alg_en_key), 256'd0);
        repeat (11) tick();
        check("k128_not_yet", 256'(key_expanded), 256'd0);
        aes_alg_done = 1'b1;
        tick();
        aes_alg_done = 1'b0;
        check("k128_key_exp", 256'(key_expanded), 256'd1);
        send_word(128'h11111111_22222222_33333333_44444444, 1'b1);
        check("latency_valid", 256'(gcm_valid), 256'd1);
        send_word(128'h00000000_00000080_00000000_00000100, 1'b1);
        send_word(128'hdeadbeef_cafef00d_01234567_89abcdef, 1'b1);
        wait_drain();
        check("k128_pulses", 256'(pulses), 256'd1);
        gcm_done = 1'b1;
        tick();
        gcm_done = 1'b0;
        check("s1_done_key_exp", 256'(key_expanded), 256'd0);
        check("s1_done_busy", 256'(busy), 256'd0);

        // AES-256 session with expansion stalled by a busy aes_top
        key_mode = 1'b1;
        send_word({16{8'hA5}}, 1'b0);
        key_mode           = 1'b0;
        aes_op_in_progress = 1'b1;
        send_word({16{8'h5A}}, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("stall_en_key", 256'(aes_alg_en_key), 256'd0);
            tick();
        end
        aes_op_in_progress = 1'b0;
        #1;
        exp_key = {{16{8'hA5}}, {16{8'h5A}}};
        check("k256_en_key", 256'(aes_alg_en_key), 256'd1);
        check("k256_key", aes_alg_key, exp_key);
        check("k256_m256", 256'(aes256_mode), 256'd1);
        check("k256_m128", 256'(aes128_mode), 256'd0);
        tick();
        check("k256_en_once", 256'(aes_alg_en_key), 256'd0);
        repeat (3) tick();
        aes_alg_done = 1'b1;
        tick();
        aes_alg_done = 1'b0;
        check("k256_key_exp", 256'(key_expanded), 256'd1);

        // Backpressure: FIFO fills at 4, head holds, then all 6 drain in order
        gcm_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_word(words[i], 1'b1);
        check("full_s_ready", 256'(s_ready), 256'd0);
        check("full_gcm_valid", 256'(gcm_valid), 256'd1);
        check("full_head", 256'(gcm_in_blk), 256'(words[0]));
        tick();
        check("full_head_hold", 256'(gcm_in_blk), 256'(words[0]));
        gcm_ready = 1'b1;
        send_word(words[4], 1'b1);
        send_word(words[5], 1'b1);
        wait_drain();
        check("k256_pulses", 256'(pulses), 256'd2);

        // gcm_done with two words queued discards them
        gcm_ready = 1'b0;
        send_word(128'hbad0_0001, 1'b0);
        send_word(128'hbad0_0002, 1'b0);
        check("queued_valid", 256'(gcm_valid), 256'd1);
        gcm_done = 1'b1;
        tick();
        gcm_done = 1'b0;
        check("flush_key_exp", 256'(key_expanded), 256'd0);
        check("flush_gcm_valid", 256'(gcm_valid), 256'd0);
        check("flush_head", 256'(gcm_in_blk), 256'd0);
        check("flush_busy", 256'(busy), 256'd0);
        gcm_ready = 1'b1;

        // Next key accepted, then reset while waiting for expansion
        send_word(k3, 1'b0);
        exp_key = {k3, 128'd0};
        check("k3_key", aes_alg_key, exp_key);
        check("k3_en_key", 256'(aes_alg_en_key), 256'd1);
        tick();
        check("k3_wait_busy", 256'(busy), 256'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_key", aes_alg_key, 256'd0);
        check("mid_rst_m128", 256'(aes128_mode), 256'd0);
        check("mid_rst_busy", 256'(busy), 256'd0);
        check("mid_rst_s_ready", 256'(s_ready), 256'd0);
        check("mid_rst_gcm_valid", 256'(gcm_valid), 256'd0);
        aes_alg_done = 1'b1;
        tick();
        aes_alg_done = 1'b0;
        repeat (3) tick();
        check("late_done_key_exp", 256'(key_expanded), 256'd0);
        check("late_done_gcm_valid", 256'(gcm_valid), 256'd0);
        check("late_done_s_ready", 256'(s_ready), 256'd1);
        check("total_pulses", 256'(pulses), 256'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
